// File: rtl/pokey_key_scan_pkg.sv
// pokey_key_scan_pkg: shared keyboard-scan types, widths and KBCODE packing.
package pokey_key_scan_pkg;
  localparam int CW = 6;
  localparam int KB_W = 8;
  localparam int KB_SHIFT_BIT = 6;
  localparam logic [CW-1:0] SHIFT_ADDR_DEF = 6'h30;
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;
  function automatic logic [KB_W-1:0] kb_pack(input logic shift, input logic [CW-1:0] code);
    logic [KB_W-1:0] kb;
    kb = '0;
    kb[KB_SHIFT_BIT] = shift;
    kb[CW-1:0] = code;
    return kb;
  endfunction
endpackage

// File: rtl/pokey_key_scan_key_cmp_latch.sv
// key_cmp_latch: candidate key-code latch with a bitwise compare against the scan address.
module key_cmp_latch
  import pokey_key_scan_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enp_i,
  input  logic          ld_i,
  input  logic [CW-1:0] d_i,
  input  logic [CW-1:0] cmp_i,
  output logic [CW-1:0] q_o,
  output logic          match_o
);
  logic [CW-1:0] latch_q, latch_d, diff;
  assign latch_d = (enp_i && ld_i) ? d_i : latch_q;
  assign diff = latch_q ^ cmp_i;
  assign match_o = ~|diff;
  assign q_o = latch_q;
  always_ff @(posedge clk) begin
    if (!rst_n) latch_q <= '0;
    else latch_q <= latch_d;
  end
endmodule

// File: rtl/pokey_key_scan.sv
// pokey_key_scan: keyboard scan counter, shift sampling and one-key debounce FSM.
module pokey_key_scan
  import pokey_key_scan_pkg::*;
#(
  parameter logic [CW-1:0] SHIFT_ADDR = SHIFT_ADDR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enp,
  input  logic            scan_en,
  input  logic            debounce_en,
  input  logic            kr1_n,
  input  logic            kr2_n,
  output logic [CW-1:0]   k_out,
  output logic [KB_W-1:0] kbcode,
  output logic            key_down,
  output logic            shift_down,
  output logic            key_irq
);
  logic [CW-1:0] k_q, k_d, latch;
  logic [KB_W-1:0] kb_q, kb_d;
  logic down_q, down_d, shift_q, shift_d, irq_q, irq_d;
  logic key, ld, match;
  state_e state_q, state_d;
  assign key = ~kr1_n;
  key_cmp_latch u_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .enp_i   (enp),
    .ld_i    (ld),
    .d_i     (k_q),
    .cmp_i   (k_q),
    .q_o     (latch),
    .match_o (match)
  );
  // Only the latched address can advance the FSM once a candidate exists.
  always_comb begin
    k_d = k_q;
    kb_d = kb_q;
    down_d = down_q;
    shift_d = shift_q;
    irq_d = 1'b0;
    state_d = state_q;
    ld = 1'b0;
    if (!scan_en) begin
      k_d = '0;
      down_d = 1'b0;
      state_d = ST_WAIT;
    end else if (enp) begin
      k_d = k_q + 1'b1;
      shift_d = (k_q == SHIFT_ADDR) ? ~kr2_n : shift_q;
      case (state_q)
        ST_WAIT: if (key) begin
          ld = 1'b1;
          state_d = debounce_en ? ST_CONFIRM : ST_HELD;
          kb_d = debounce_en ? kb_q : kb_pack(shift_q, k_q);
          down_d = ~debounce_en;
          irq_d = ~debounce_en;
        end
        ST_CONFIRM: if (match) begin
          state_d = key ? ST_HELD : ST_WAIT;
          kb_d = key ? kb_pack(shift_q, latch) : kb_q;
          down_d = key;
          irq_d = key;
        end
        ST_HELD: if (match && !key) state_d = ST_RELEASE;
        default: if (match) begin
          state_d = key ? ST_HELD : ST_WAIT;
          down_d = key;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q <= '0;
      kb_q <= '0;
      down_q <= 1'b0;
      shift_q <= 1'b0;
      irq_q <= 1'b0;
      state_q <= ST_WAIT;
    end else begin
      k_q <= k_d;
      kb_q <= kb_d;
      down_q <= down_d;
      shift_q <= shift_d;
      irq_q <= irq_d;
      state_q <= state_d;
    end
  end
  assign k_out = k_q;
  assign kbcode = kb_q;
  assign key_down = down_q;
  assign shift_down = shift_q;
  assign key_irq = irq_q;
endmodule

// File: tb/tb_pokey_key_scan.sv
// tb_pokey_key_scan: scenario tasks checked against a press-lifecycle reference model.
module tb_pokey_key_scan;
  logic clk = 1'b0, rst_n = 1'b0, enp = 1'b0, scan_en = 1'b1, debounce_en = 1'b1;
  logic kr1_n = 1'b1, kr2_n = 1'b1;
  logic [5:0] k_out;
  logic [7:0] kbcode;
  logic key_down, shift_down, key_irq;
  int errors = 0, checks = 0;
  logic [5:0] e_addr, e_cand;
  logic [7:0] e_kb;
  logic e_down, e_shift, e_irq, e_pend;
  int e_miss;

  pokey_key_scan dut (
    .clk(clk), .rst_n(rst_n), .enp(enp), .scan_en(scan_en), .debounce_en(debounce_en),
    .kr1_n(kr1_n), .kr2_n(kr2_n), .k_out(k_out), .kbcode(kbcode),
    .key_down(key_down), .shift_down(shift_down), .key_irq(key_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [16:0] obs_v();
    return {k_out, kbcode, key_down, shift_down, key_irq};
  endfunction

  function automatic logic [16:0] exp_v();
    return {e_addr, e_kb, e_down, e_shift, e_irq};
  endfunction

  task automatic model_clear();
    e_addr = '0; e_cand = '0; e_kb = '0;
    e_down = 0; e_shift = 0; e_irq = 0; e_pend = 0; e_miss = 0;
  endtask

  // A press is pending until its address comes round again; a held key is
  // released after two consecutive unpressed visits to its address.
  task automatic tick(input logic k1n, input logic k2n);
    logic key, acc;
    @(negedge clk); enp = 1'b1; kr1_n = k1n; kr2_n = k2n;
    @(negedge clk); enp = 1'b0;
    key = !k1n; acc = 0; e_irq = 0;
    if (!e_pend && !e_down) begin
      if (key && debounce_en) begin e_pend = 1; e_cand = e_addr; end
      else if (key) acc = 1;
    end else if (e_addr == e_cand) begin
      if (e_pend) begin e_pend = 0; acc = key; end
      else begin
        e_miss = key ? 0 : e_miss + 1;
        if (e_miss == 2) begin e_down = 0; e_miss = 0; end
      end
    end
    if (acc) begin e_down = 1; e_irq = 1; e_kb = {1'b0, e_shift, e_addr}; e_cand = e_addr; e_miss = 0; end
    if (e_addr == 6'h30) e_shift = !k2n;
    e_addr = e_addr + 1;
  endtask

  task automatic test_reset();
    rst_n = 0; kr1_n = 0;
    repeat (3) begin @(negedge clk); enp = ~enp; end
    @(negedge clk);
    model_clear();
    checks++;
    if (obs_v() !== exp_v()) begin errors++; $display("FAIL reset: got %h exp %h", obs_v(), exp_v()); end
    rst_n = 1; enp = 0; kr1_n = 1;
    tick(1'b1, 1'b1);
    checks++;
    if (k_out !== 6'd1) begin errors++; $display("FAIL reset_first_tick: k_out got %h exp 01", k_out); end
  endtask

  task automatic test_debounce_release();
    int first = -1, hit = -1, drop = -1, irqs = 0;
    debounce_en = 1;
    for (int i = 0; i < 200 && hit < 0; i++) begin
      if (e_addr == 6'h12 && first < 0) first = i;
      tick(e_addr != 6'h12, 1'b1);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL debounce t%0d: got %h exp %h", i, obs_v(), exp_v()); end
      if (key_irq) hit = i;
    end
    checks++;
    if (hit - first != 64) begin errors++; $display("FAIL debounce_latency: got %0d exp 64", hit - first); end
    checks++;
    if ({kbcode, key_down} !== {8'h12, 1'b1}) begin errors++; $display("FAIL debounce_code: got %h/%b exp 12/1", kbcode, key_down); end
    @(negedge clk);
    checks++;
    if (key_irq !== 1'b0) begin errors++; $display("FAIL irq_pulse: got %b exp 0", key_irq); end
    for (int j = 0; j < 130; j++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL release t%0d: got %h exp %h", j, obs_v(), exp_v()); end
      if (!key_down && drop < 0) drop = j;
      if (key_irq) irqs++;
    end
    checks++;
    if (drop != 127 || irqs != 0) begin errors++; $display("FAIL release_timing: drop %0d irqs %0d exp 127/0", drop, irqs); end
  endtask

  task automatic test_bounce();
    logic seen = 0;
    int irqs = 0;
    debounce_en = 1;
    for (int i = 0; i < 140; i++) begin
      tick(!(e_addr == 6'h12 && !seen), 1'b1);
      if (e_addr == 6'h13) seen = 1;
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL bounce t%0d: got %h exp %h", i, obs_v(), exp_v()); end
      if (key_irq || key_down) irqs++;
    end
    checks++;
    if (irqs != 0) begin errors++; $display("FAIL bounce_reject: got %0d active ticks exp 0", irqs); end
  endtask

  task automatic test_shift_nodebounce();
    int hit = -1, extra = 0;
    debounce_en = 0;
    for (int i = 0; i < 200 && hit < 0; i++) begin
      tick(!(e_shift && (e_addr == 6'h05 || e_addr == 6'h07)), e_addr != 6'h30);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL shift t%0d: got %h exp %h", i, obs_v(), exp_v()); end
      if (key_irq) hit = i;
    end
    checks++;
    if (kbcode !== 8'h45 || hit < 0) begin errors++; $display("FAIL shift_code: got %h exp 45", kbcode); end
    for (int i = 0; i < 64; i++) begin
      tick(!(e_addr == 6'h05 || e_addr == 6'h07), e_addr != 6'h30);
      if (key_irq) extra++;
    end
    checks++;
    if (extra != 0 || kbcode !== 8'h45) begin errors++; $display("FAIL rollover: irqs %0d code %h exp 0/45", extra, kbcode); end
    for (int i = 0; i < 140; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL shift_release t%0d: got %h exp %h", i, obs_v(), exp_v()); end
    end
  endtask

  task automatic test_scan_disable();
    int hit = -1;
    debounce_en = 1;
    for (int i = 0; i < 100 && !e_pend; i++) tick(e_addr != 6'h12, 1'b1);
    repeat (5) tick(1'b1, 1'b1);
    scan_en = 0;
    @(negedge clk); enp = 1;
    @(negedge clk); enp = 0;
    @(negedge clk);
    e_addr = 0; e_pend = 0; e_down = 0; e_miss = 0; e_irq = 0;
    checks++;
    if ({k_out, kbcode, key_down, key_irq} !== {6'h00, 8'h45, 1'b0, 1'b0}) begin
      errors++; $display("FAIL scan_disable: got %h exp %h", {k_out, kbcode, key_down, key_irq}, {6'h00, 8'h45, 2'b00});
    end
    scan_en = 1;
    for (int i = 0; i < 90; i++) begin
      tick(e_addr != 6'h12, 1'b1);
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL rescan t%0d: got %h exp %h", i, obs_v(), exp_v()); end
      if (key_irq && hit < 0) hit = i;
    end
    checks++;
    if (hit != 82) begin errors++; $display("FAIL rescan_restart: irq tick %0d exp 82", hit); end
    for (int i = 0; i < 140; i++) tick(1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [5:0] hold = 0;
    logic on = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) begin
        hold = 6'($urandom_range(0, 63));
        on = 1'($urandom_range(0, 1));
        debounce_en = 1'($urandom_range(0, 1));
      end
      tick(!((on && e_addr == hold) || $urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_v() !== exp_v()) begin errors++; $display("FAIL random t%0d: got %h exp %h", i, obs_v(), exp_v()); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_release();
    test_bounce();
    test_shift_nodebounce();
    test_scan_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
